// File: rtl/marray_ctrl_pkg.sv
// Shared buffer geometry, FSM state encoding and shift-code encoding for the
// matrix-array tile controller.
package Common;

    localparam int OBufBank  = 4;
    localparam int OBufDepth = 16;
    localparam int ABufDepth = 32;
    localparam int WBufDepth = 32;
    localparam int SBufDepth = 16;

    localparam int OBankW = $clog2(OBufBank);
    localparam int OAddrW = $clog2(OBufDepth);
    localparam int AAddrW = $clog2(ABufDepth);
    localparam int WAddrW = $clog2(WBufDepth);
    localparam int SAddrW = $clog2(SBufDepth);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SH00 = 2'b00,
        SH01 = 2'b01,
        SH10 = 2'b10,
        SH11 = 2'b11
    } mshift_e;

    // Index of the final pass for a {aOutlier, wOutlier} mode (P-1).
    function automatic logic [1:0] last_pass_idx(input logic [1:0] mode);
        case (mode)
            2'b00:   return 2'd0;
            2'b11:   return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/marray_ctrl_mshift_seq.sv
// Per-step pass sequencer: walks the passes of one accumulate step and emits
// the shift code for each pass, flagging the last pass of the step.
module mshift_seq
    import Common::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       advance,
    output logic [1:0] mShift,
    output logic       lastPass
);

    logic [1:0] pass_q;

    assign lastPass = (pass_q == last_pass_idx(mode));

    // Wraps to zero after the last pass, so it rests at 0 between tiles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pass_q <= 2'd0;
        end else if (advance) begin
            pass_q <= lastPass ? 2'd0 : pass_q + 2'd1;
        end
    end

    always_comb begin
        mShift = SH00;
        case (mode)
            2'b10:   mShift = pass_q[0] ? SH01 : SH00;
            2'b01:   mShift = pass_q[0] ? SH10 : SH00;
            2'b11:   mShift = pass_q;
            default: mShift = SH00;
        endcase
    end

endmodule

// File: rtl/marray_ctrl.sv
// Tile controller: accepts a tile command, issues K*P back-to-back array
// cycles with buffer reads, drains the pipeline and pulses tileDone.
module marray_ctrl
    import Common::*;
#(
    parameter int DrainLat = 6,
    parameter int KWidth   = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cmdValid,
    output logic                             cmdReady,
    input  logic                             cmdAOutlier,
    input  logic                             cmdWOutlier,
    input  logic [KWidth-1:0]                cmdKSteps,
    input  logic [AAddrW-1:0]                cmdABase,
    input  logic [WAddrW-1:0]                cmdWBase,
    input  logic [SAddrW-1:0]                cmdSBase,
    input  logic [OAddrW-1:0]                cmdOBufAddr,
    input  logic [OBankW-1:0]                cmdOBufBank,
    output logic                             aBufREn,
    output logic [AAddrW-1:0]                aBufRAddr,
    output logic                             wBufREn,
    output logic [WAddrW-1:0]                wBufRAddr,
    output logic                             sBufREn,
    output logic [SAddrW-1:0]                sBufRAddr,
    output logic                             mValid,
    output logic [1:0]                       mShift,
    output logic                             mOutTileFinish,
    output logic [OBufBank-1:0][OAddrW-1:0]  oBufAddr,
    output logic [OBufBank-1:0]              oBufBankSel,
    input  logic                             mvWSync,
    output logic                             tileDone,
    output logic                             busy,
    output logic [7:0]                       wSyncCnt
);

    localparam int DrnW = (DrainLat > 1) ? $clog2(DrainLat) : 1;
    localparam logic [DrnW-1:0]   DrainEnd = DrnW'(DrainLat - 1);
    localparam logic [AAddrW-1:0] ALast    = AAddrW'(ABufDepth - 1);
    localparam logic [WAddrW-1:0] WLast    = WAddrW'(WBufDepth - 1);
    localparam logic [SAddrW-1:0] SLast    = SAddrW'(SBufDepth - 1);
    localparam logic [KWidth-1:0] KOne     = KWidth'(1);

    state_e              state_q;
    logic [KWidth-1:0]   k_q;
    logic [KWidth-1:0]   klast_q;
    logic [1:0]          mode_q;
    logic [AAddrW-1:0]   a_addr_q;
    logic [WAddrW-1:0]   w_addr_q;
    logic [SAddrW-1:0]   s_addr_q;
    logic [OAddrW-1:0]   obuf_addr_q;
    logic [OBankW-1:0]   bank_q;
    logic [DrnW-1:0]     drain_q;
    logic [7:0]          wsync_q;

    logic issue_w;
    logic last_pass_w;
    logic last_step_w;
    logic accept_w;

    assign issue_w     = (state_q == ISSUE);
    assign last_step_w = (k_q == klast_q);
    assign accept_w    = cmdValid && (state_q == IDLE);

    mshift_seq u_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode_q),
        .advance  (issue_w),
        .mShift   (mShift),
        .lastPass (last_pass_w)
    );

    // Read addresses live in their own registers and return to 0 on leaving
    // ISSUE, so they can be driven straight out without gating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            klast_q     <= '0;
            mode_q      <= 2'b00;
            a_addr_q    <= '0;
            w_addr_q    <= '0;
            s_addr_q    <= '0;
            obuf_addr_q <= '0;
            bank_q      <= '0;
            drain_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmdValid) begin
                        state_q     <= ISSUE;
                        k_q         <= '0;
                        klast_q     <= (cmdKSteps == '0) ? '0 : cmdKSteps - KOne;
                        mode_q      <= {cmdAOutlier, cmdWOutlier};
                        a_addr_q    <= cmdABase;
                        w_addr_q    <= cmdWBase;
                        s_addr_q    <= cmdSBase;
                        obuf_addr_q <= cmdOBufAddr;
                        bank_q      <= cmdOBufBank;
                    end
                end
                ISSUE: begin
                    if (last_pass_w) begin
                        if (last_step_w) begin
                            state_q  <= DRAIN;
                            drain_q  <= '0;
                            a_addr_q <= '0;
                            w_addr_q <= '0;
                            s_addr_q <= '0;
                        end else begin
                            k_q      <= k_q + KOne;
                            a_addr_q <= (a_addr_q == ALast) ? '0 : a_addr_q + AAddrW'(1);
                            w_addr_q <= (w_addr_q == WLast) ? '0 : w_addr_q + WAddrW'(1);
                            s_addr_q <= (s_addr_q == SLast) ? '0 : s_addr_q + SAddrW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_q == DrainEnd) begin
                        state_q <= IDLE;
                    end else begin
                        drain_q <= drain_q + DrnW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Command accept clears the count even if a sync pulse lands that cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wsync_q <= 8'd0;
        end else if (accept_w) begin
            wsync_q <= 8'd0;
        end else if (mvWSync && (wsync_q != 8'hFF)) begin
            wsync_q <= wsync_q + 8'd1;
        end
    end

    assign cmdReady       = (state_q == IDLE);
    assign busy           = (state_q == ISSUE) || (state_q == DRAIN);
    assign mValid         = issue_w;
    assign aBufREn        = issue_w;
    assign wBufREn        = issue_w;
    assign sBufREn        = issue_w;
    assign aBufRAddr      = a_addr_q;
    assign wBufRAddr      = w_addr_q;
    assign sBufRAddr      = s_addr_q;
    assign mOutTileFinish = issue_w && last_pass_w && last_step_w;
    assign tileDone       = (state_q == DRAIN) && (drain_q == DrainEnd);
    assign wSyncCnt       = wsync_q;

    for (genvar gi = 0; gi < OBufBank; gi++) begin : g_obank
        assign oBufAddr[gi]    = busy ? obuf_addr_q : '0;
        assign oBufBankSel[gi] = busy && (bank_q == OBankW'(gi));
    end

endmodule

// File: tb/tb_marray_ctrl.sv
// Directed bench for marray_ctrl: table of tile commands with hand-computed
// cycle counts, plus hand-written sequences for back-pressure, sync and reset.
module tb_marray_ctrl;
    import Common::*;

    localparam int DrainLat = 6;
    localparam int KWidth   = 8;

    logic                            clk = 1'b0;
    logic                            rst_n;
    logic                            cmdValid;
    logic                            cmdReady;
    logic                            cmdAOutlier;
    logic                            cmdWOutlier;
    logic [KWidth-1:0]               cmdKSteps;
    logic [AAddrW-1:0]               cmdABase;
    logic [WAddrW-1:0]               cmdWBase;
    logic [SAddrW-1:0]               cmdSBase;
    logic [OAddrW-1:0]               cmdOBufAddr;
    logic [OBankW-1:0]               cmdOBufBank;
    logic                            aBufREn;
    logic [AAddrW-1:0]               aBufRAddr;
    logic                            wBufREn;
    logic [WAddrW-1:0]               wBufRAddr;
    logic                            sBufREn;
    logic [SAddrW-1:0]               sBufRAddr;
    logic                            mValid;
    logic [1:0]                      mShift;
    logic                            mOutTileFinish;
    logic [OBufBank-1:0][OAddrW-1:0] oBufAddr;
    logic [OBufBank-1:0]             oBufBankSel;
    logic                            mvWSync;
    logic                            tileDone;
    logic                            busy;
    logic [7:0]                      wSyncCnt;

    marray_ctrl #(.DrainLat(DrainLat), .KWidth(KWidth)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmdValid       (cmdValid),
        .cmdReady       (cmdReady),
        .cmdAOutlier    (cmdAOutlier),
        .cmdWOutlier    (cmdWOutlier),
        .cmdKSteps      (cmdKSteps),
        .cmdABase       (cmdABase),
        .cmdWBase       (cmdWBase),
        .cmdSBase       (cmdSBase),
        .cmdOBufAddr    (cmdOBufAddr),
        .cmdOBufBank    (cmdOBufBank),
        .aBufREn        (aBufREn),
        .aBufRAddr      (aBufRAddr),
        .wBufREn        (wBufREn),
        .wBufRAddr      (wBufRAddr),
        .sBufREn        (sBufREn),
        .sBufRAddr      (sBufRAddr),
        .mValid         (mValid),
        .mShift         (mShift),
        .mOutTileFinish (mOutTileFinish),
        .oBufAddr       (oBufAddr),
        .oBufBankSel    (oBufBankSel),
        .mvWSync        (mvWSync),
        .tileDone       (tileDone),
        .busy           (busy),
        .wSyncCnt       (wSyncCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic a_out;
        logic w_out;
        int   k;
        int   abase;
        int   wbase;
        int   sbase;
        int   oaddr;
        int   obank;
        int   exp_cycles;
        int   exp_last_a;
    } vec_t;

    vec_t vecs[5];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected shift code for a pass of one step, by {aOutlier, wOutlier}.
    function automatic int exp_shift(input logic a, input logic w, input int pass);
        if (a && w)  return pass;
        if (a)       return pass;
        if (w)       return pass * 2;
        return 0;
    endfunction

    task automatic drive_fields(input vec_t v);
        cmdAOutlier = v.a_out;
        cmdWOutlier = v.w_out;
        cmdKSteps   = KWidth'(v.k);
        cmdABase    = AAddrW'(v.abase);
        cmdWBase    = WAddrW'(v.wbase);
        cmdSBase    = SAddrW'(v.sbase);
        cmdOBufAddr = OAddrW'(v.oaddr);
        cmdOBufBank = OBankW'(v.obank);
    endtask

    task automatic start_cmd(input vec_t v, input bit sync);
        chk("ready_before_cmd", cmdReady, 1);
        drive_fields(v);
        cmdValid = 1'b1;
        mvWSync  = sync;
        @(negedge clk);
    endtask

    // Called at the first ISSUE negedge; returns one negedge after the
    // first idle cycle following tileDone.
    task automatic body(input vec_t v, input bit hold, input bit pulse, input vec_t nxt);
        int p;
        int kk;
        int pass;
        p = (v.a_out ? 2 : 1) * (v.w_out ? 2 : 1);
        for (int n = 0; n < v.exp_cycles; n++) begin
            kk   = n / p;
            pass = n % p;
            chk("mValid", mValid, 1);
            chk("aBufREn", aBufREn, 1);
            chk("wBufREn", wBufREn, 1);
            chk("sBufREn", sBufREn, 1);
            chk("aBufRAddr", aBufRAddr, (v.abase + kk) % ABufDepth);
            chk("wBufRAddr", wBufRAddr, (v.wbase + kk) % WBufDepth);
            chk("sBufRAddr", sBufRAddr, (v.sbase + kk) % SBufDepth);
            chk("mShift", mShift, exp_shift(v.a_out, v.w_out, pass));
            chk("mOutTileFinish", mOutTileFinish, (n == v.exp_cycles - 1) ? 1 : 0);
            chk("oBufBankSel", oBufBankSel, 1 << v.obank);
            for (int b = 0; b < OBufBank; b++) chk("oBufAddr", oBufAddr[b], v.oaddr);
            chk("busy_issue", busy, 1);
            chk("cmdReady_issue", cmdReady, 0);
            if (n == 0) chk("wSyncCnt_start", wSyncCnt, 0);
            if (n == v.exp_cycles - 1) chk("last_aBufRAddr", aBufRAddr, v.exp_last_a);
            if (n == 0) begin
                mvWSync = 1'b0;
                if (hold) drive_fields(nxt);
                else      cmdValid = 1'b0;
            end
            if (pulse && n == 1) begin
                drive_fields(nxt);
                cmdValid = 1'b1;
            end
            if (pulse && n == 2) cmdValid = 1'b0;
            @(negedge clk);
        end
        for (int d = 0; d < DrainLat; d++) begin
            chk("mValid_drain", mValid, 0);
            chk("aBufREn_drain", aBufREn, 0);
            chk("aBufRAddr_drain", aBufRAddr, 0);
            chk("mShift_drain", mShift, 0);
            chk("finish_drain", mOutTileFinish, 0);
            chk("tileDone", tileDone, (d == DrainLat - 1) ? 1 : 0);
            chk("busy_drain", busy, 1);
            chk("bankSel_drain", oBufBankSel, 1 << v.obank);
            @(negedge clk);
        end
        chk("ready_after", cmdReady, 1);
        chk("busy_after", busy, 0);
        chk("tileDone_after", tileDone, 0);
        chk("bankSel_after", oBufBankSel, 0);
        chk("oBufAddr_after", oBufAddr[v.obank], 0);
        @(negedge clk);
        if (pulse) begin
            chk("dropped_busy", busy, 0);
            chk("dropped_mValid", mValid, 0);
        end
        $display("tile mode=%b%b K=%0d abase=%0d wbase=%0d sbase=%0d cycles=%0d hold=%0d pulse=%0d done",
                 v.a_out, v.w_out, v.k, v.abase, v.wbase, v.sbase, v.exp_cycles, hold, pulse);
    endtask

    initial begin
        vec_t rv;
        int   seen;

        vecs[0] = '{a_out:1'b0, w_out:1'b0, k:4, abase:10, wbase:3,  sbase:5,  oaddr:7,  obank:2, exp_cycles:4, exp_last_a:13};
        vecs[1] = '{a_out:1'b1, w_out:1'b1, k:2, abase:0,  wbase:31, sbase:15, oaddr:15, obank:3, exp_cycles:8, exp_last_a:1};
        vecs[2] = '{a_out:1'b1, w_out:1'b0, k:0, abase:20, wbase:4,  sbase:2,  oaddr:0,  obank:0, exp_cycles:2, exp_last_a:20};
        vecs[3] = '{a_out:1'b0, w_out:1'b0, k:3, abase:31, wbase:30, sbase:14, oaddr:9,  obank:1, exp_cycles:3, exp_last_a:1};
        vecs[4] = '{a_out:1'b0, w_out:1'b1, k:3, abase:5,  wbase:6,  sbase:7,  oaddr:3,  obank:2, exp_cycles:6, exp_last_a:7};
        rv      = '{a_out:1'b0, w_out:1'b0, k:8, abase:4,  wbase:4,  sbase:4,  oaddr:5,  obank:1, exp_cycles:8, exp_last_a:11};

        rst_n = 1'b0;
        cmdValid = 1'b0;
        mvWSync = 1'b0;
        drive_fields(vecs[0]);
        repeat (3) @(negedge clk);
        chk("rst_cmdReady", cmdReady, 1);
        chk("rst_mValid", mValid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tileDone", tileDone, 0);
        chk("rst_wSyncCnt", wSyncCnt, 0);
        chk("rst_bankSel", oBufBankSel, 0);
        chk("rst_aBufRAddr", aBufRAddr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset sequence done");

        for (int i = 0; i < 3; i++) begin
            mvWSync = 1'b1;
            @(negedge clk);
            mvWSync = 1'b0;
            @(negedge clk);
        end
        chk("wSync_idle", wSyncCnt, 3);
        mvWSync = 1'b1;
        repeat (300) @(negedge clk);
        mvWSync = 1'b0;
        chk("wSync_sat", wSyncCnt, 255);
        $display("wsync idle count and saturation done");

        start_cmd(vecs[0], 1'b1);
        body(vecs[0], 1'b0, 1'b0, vecs[0]);
        for (int i = 1; i < 5; i++) begin
            start_cmd(vecs[i], 1'b0);
            body(vecs[i], 1'b0, 1'b0, vecs[i]);
        end

        start_cmd(vecs[3], 1'b0);
        body(vecs[3], 1'b1, 1'b0, vecs[1]);
        body(vecs[1], 1'b0, 1'b0, vecs[1]);

        start_cmd(vecs[0], 1'b0);
        body(vecs[0], 1'b0, 1'b1, vecs[4]);

        start_cmd(rv, 1'b0);
        cmdValid = 1'b0;
        mvWSync  = 1'b1;
        @(negedge clk);
        mvWSync = 1'b0;
        chk("wSync_issue", wSyncCnt, 1);
        @(negedge clk);
        chk("mValid_3rd", mValid, 1);
        chk("aBufRAddr_3rd", aBufRAddr, 6);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_mValid", mValid, 0);
        chk("abort_cmdReady", cmdReady, 1);
        chk("abort_busy", busy, 0);
        chk("abort_wSyncCnt", wSyncCnt, 0);
        chk("abort_bankSel", oBufBankSel, 0);
        chk("abort_aBufRAddr", aBufRAddr, 0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (tileDone) seen++;
            @(negedge clk);
        end
        chk("abort_no_tileDone", seen, 0);
        $display("reset abort mid-issue done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
